chan_sequencer_3b: RTL

Upstream stage for the 3-to-8 decoder: generates the 3-bit channel select that drives the decoder's `in[2:0]`. Each enabled channel is visited in ascending order, and `sel` is held for a programmable dwell time on each. Runs either a single sweep or continuous sweeps. Start, stop, busy and done signalling go to the controlling logic.

---
 rtl/chan_sequencer_3b.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/chan_sequencer_3b.sv
// -----------------------------------------------------------------------------
// chan_sequencer_3b
//
// Purpose:
//   Generates the 3-bit channel select that feeds a 3-to-8 decoder. Each
//   channel enabled in the latched mask is visited in ascending order and
//   held for dwell+1 cycles. Runs a single sweep (mode 0) or repeats the
//   sweep continuously (mode 1) until stopped.
//
// Parameters:
//   DWELL_W    width of the dwell input and the internal dwell counter
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle request to begin a sweep (IDLE only)
//   stop       in   abort the current sweep; wins over start
//   mode       in   0 = single sweep, 1 = continuous
//   mask       in   [7:0] channel enable mask, bit n enables channel n
//   dwell      in   [DWELL_W-1:0] each channel is held dwell+1 cycles
//   sel        out  [2:0] registered channel select
//   sel_valid  out  high while sel carries a live channel
//   busy       out  high while running
//   done       out  one-cycle pulse when a single sweep completes
//   sweep_cnt  out  [7:0] continuous-mode wrap count
//
// Configuration:
//   CHAN_SEQ_SWEEP_CNT_EN  defined: sweep_cnt is a wrapping 8-bit counter of
//                          continuous-mode wraps, cleared only by rst.
//                          undefined: sweep_cnt is tied to 8'h00.
// -----------------------------------------------------------------------------
module chan_sequencer_3b #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic [7:0]         sweep_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [2:0]         sel_q;
    logic               sel_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [7:0]         mask_q;
    logic               mode_q;

    // Lowest set bit of m (0 if none; callers guarantee m != 0).
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next set bit strictly above cur; MSB of the result flags "found".
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    logic [2:0] start_ch;     // first channel of a new sweep, from the live mask
    logic [2:0] wrap_ch;      // first channel of a repeated sweep, from the latched mask
    logic [3:0] next_ch;      // {found, index} of the next higher latched channel

    always_comb begin
        start_ch = lowest_bit(mask);
        wrap_ch  = lowest_bit(mask_q);
        next_ch  = next_above(mask_q, sel_q);
    end

`ifdef CHAN_SEQ_SWEEP_CNT_EN
    logic [7:0] sweep_cnt_q;
    logic [7:0] sweep_cnt_d;
    logic       wrap_evt;

    // A wrap is the end-of-sweep step in continuous mode without a stop.
    assign wrap_evt    = (state_q == ST_RUN) && !stop && (cnt_q == '0)
                         && !next_ch[3] && mode_q;
    assign sweep_cnt_d = wrap_evt ? sweep_cnt_q + 8'd1 : sweep_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_cnt_q <= 8'd0;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`else
    assign sweep_cnt = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= 3'd0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            mask_q      <= 8'd0;
            mode_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // stop has priority; an empty mask never starts a sweep
                    if (start && !stop && (mask != 8'd0)) begin
                        mask_q      <= mask;
                        dwell_q     <= dwell;
                        mode_q      <= mode;
                        sel_q       <= start_ch;
                        cnt_q       <= dwell;
                        sel_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q     <= ST_IDLE;
                        sel_q       <= 3'd0;
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (next_ch[3]) begin
                        sel_q <= next_ch[2:0];
                        cnt_q <= dwell_q;
                    end else if (mode_q) begin
                        sel_q <= wrap_ch;
                        cnt_q <= dwell_q;
                    end else begin
                        state_q     <= ST_IDLE;
                        sel_q       <= 3'd0;
                        sel_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
